// File: rtl/ptw_axi_read_bridge.sv
// Page-table-walk memory port: arbitrates ITLB/DTLB PTE read pulses onto a single-beat
// AXI4 read master and returns each PTE to its requester as a one-cycle response pulse.
module ptw_axi_read_bridge #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 64,
    parameter int PADDR_WIDTH = 56
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   tlb_flush_i,

    input  logic                   i_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]  i_req_addr_i,
    output logic                   i_resp_valid_o,
    output logic [DATA_WIDTH-1:0]  i_resp_data_o,
    output logic                   i_access_fault_o,

    input  logic                   d_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]  d_req_addr_i,
    output logic                   d_resp_valid_o,
    output logic [DATA_WIDTH-1:0]  d_resp_data_o,
    output logic                   d_access_fault_o,

    output logic                   m_arvalid_o,
    input  logic                   m_arready_i,
    output logic [PADDR_WIDTH-1:0] m_araddr_o,
    output logic                   m_arid_o,
    output logic [7:0]             m_arlen_o,
    output logic [2:0]             m_arsize_o,
    output logic [1:0]             m_arburst_o,
    output logic [2:0]             m_arprot_o,

    input  logic                   m_rvalid_i,
    output logic                   m_rready_o,
    input  logic [DATA_WIDTH-1:0]  m_rdata_i,
    input  logic [1:0]             m_rresp_i,
    input  logic                   m_rlast_i,
    input  logic                   m_rid_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic                   iPending_q, iPending_d;
    logic                   dPending_q, dPending_d;
    logic [PADDR_WIDTH-1:0] iAddr_q, iAddr_d;
    logic [PADDR_WIDTH-1:0] dAddr_q, dAddr_d;
    logic                   rrIsD_q, rrIsD_d;
    logic                   arId_q, arId_d;
    logic [2:0]             arProt_q, arProt_d;
    logic [PADDR_WIDTH-1:0] arAddr_q, arAddr_d;
    logic                   drop_q, drop_d;
    logic                   iRespValid_q, iRespValid_d;
    logic                   dRespValid_q, dRespValid_d;
    logic [DATA_WIDTH-1:0]  iRespData_q, iRespData_d;
    logic [DATA_WIDTH-1:0]  dRespData_q, dRespData_d;
    logic                   iFault_q, iFault_d;
    logic                   dFault_q, dFault_d;

    logic                   busy;
    logic                   iCapture, dCapture;
    logic                   iWant, dWant, pickD;
    logic [PADDR_WIDTH-1:0] winAddr;

    // RLAST/RID and the address bits above the physical width carry no information here.
    logic unused_ok;
    assign unused_ok = ^{m_rlast_i, m_rid_i,
                         i_req_addr_i[ADDR_WIDTH-1:PADDR_WIDTH],
                         d_req_addr_i[ADDR_WIDTH-1:PADDR_WIDTH]};

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            iPending_q   <= 1'b0;
            dPending_q   <= 1'b0;
            iAddr_q      <= '0;
            dAddr_q      <= '0;
            rrIsD_q      <= 1'b0;
            arId_q       <= 1'b0;
            arProt_q     <= 3'b000;
            arAddr_q     <= '0;
            drop_q       <= 1'b0;
            iRespValid_q <= 1'b0;
            dRespValid_q <= 1'b0;
            iRespData_q  <= '0;
            dRespData_q  <= '0;
            iFault_q     <= 1'b0;
            dFault_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            iPending_q   <= iPending_d;
            dPending_q   <= dPending_d;
            iAddr_q      <= iAddr_d;
            dAddr_q      <= dAddr_d;
            rrIsD_q      <= rrIsD_d;
            arId_q       <= arId_d;
            arProt_q     <= arProt_d;
            arAddr_q     <= arAddr_d;
            drop_q       <= drop_d;
            iRespValid_q <= iRespValid_d;
            dRespValid_q <= dRespValid_d;
            iRespData_q  <= iRespData_d;
            dRespData_q  <= dRespData_d;
            iFault_q     <= iFault_d;
            dFault_q     <= dFault_d;
        end
    end

    // A side that already waits or owns the bus ignores further pulses; flush drops them too.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        iCapture = i_req_valid_i && !tlb_flush_i && !iPending_q && !(busy && !arId_q);
        dCapture = d_req_valid_i && !tlb_flush_i && !dPending_q && !(busy && arId_q);
        iWant    = !tlb_flush_i && (iPending_q || iCapture);
        dWant    = !tlb_flush_i && (dPending_q || dCapture);
        iAddr_d  = iCapture ? i_req_addr_i[PADDR_WIDTH-1:0] : iAddr_q;
        dAddr_d  = dCapture ? d_req_addr_i[PADDR_WIDTH-1:0] : dAddr_q;

        state_d      = state_q;
        iPending_d   = iWant;
        dPending_d   = dWant;
        rrIsD_d      = rrIsD_q;
        arId_d       = arId_q;
        arProt_d     = arProt_q;
        arAddr_d     = arAddr_q;
        drop_d       = drop_q;
        iRespValid_d = 1'b0;
        dRespValid_d = 1'b0;
        iRespData_d  = iRespData_q;
        dRespData_d  = dRespData_q;
        iFault_d     = iFault_q;
        dFault_d     = dFault_q;
        pickD        = dWant && (!iWant || rrIsD_q);
        winAddr      = pickD ? dAddr_d : iAddr_d;

        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (iWant || dWant) begin
                    if (iWant && dWant) begin
                        rrIsD_d = !rrIsD_q;
                    end
                    if (pickD) begin
                        dPending_d = 1'b0;
                    end else begin
                        iPending_d = 1'b0;
                    end
                    arId_d   = pickD;
                    arProt_d = {!pickD, 1'b0, 1'b1};
                    arAddr_d = {winAddr[PADDR_WIDTH-1:3], 3'b000};
                    state_d  = ST_AR;
                end
            end
            ST_AR: begin
                if (tlb_flush_i) begin
                    drop_d = 1'b1;
                end
                if (m_arready_i) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (tlb_flush_i) begin
                    drop_d = 1'b1;
                end
                if (m_rvalid_i) begin
                    state_d = ST_RESP;
                    if (!drop_q && !tlb_flush_i) begin
                        if (arId_q) begin
                            dRespValid_d = 1'b1;
                            dRespData_d  = m_rdata_i;
                            dFault_d     = (m_rresp_i != 2'b00);
                        end else begin
                            iRespValid_d = 1'b1;
                            iRespData_d  = m_rdata_i;
                            iFault_d     = (m_rresp_i != 2'b00);
                        end
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_arvalid_o      = (state_q == ST_AR);
    assign m_rready_o       = (state_q == ST_R);
    assign m_araddr_o       = arAddr_q;
    assign m_arid_o         = arId_q;
    assign m_arprot_o       = arProt_q;
    assign m_arlen_o        = 8'd0;
    assign m_arsize_o       = 3'd3;
    assign m_arburst_o      = 2'b01;
    assign i_resp_valid_o   = iRespValid_q;
    assign i_resp_data_o    = iRespData_q;
    assign i_access_fault_o = iFault_q;
    assign d_resp_valid_o   = dRespValid_q;
    assign d_resp_data_o    = dRespData_q;
    assign d_access_fault_o = dFault_q;

endmodule

// File: tb/tb_ptw_axi_read_bridge.sv
// Directed bench for ptw_axi_read_bridge: the bench plays the AXI slave and both TLBs,
// with every expected value written out by hand.
module tb_ptw_axi_read_bridge;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        iReq = 1'b0, dReq = 1'b0;
    logic [63:0] iAddr = '0, dAddr = '0;
    logic        iRespValid, dRespValid, iFault, dFault;
    logic [63:0] iRespData, dRespData;
    logic        arValid, arReady = 1'b1, arId, rReady;
    logic [55:0] arAddr;
    logic [7:0]  arLen;
    logic [2:0]  arSize, arProt;
    logic [1:0]  arBurst;
    logic        rValid = 1'b0;
    logic [63:0] rData = '0;
    logic [1:0]  rResp = 2'b00;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    ptw_axi_read_bridge dut (
        .clk_i(clk), .rstn_i(rstn), .tlb_flush_i(flush),
        .i_req_valid_i(iReq), .i_req_addr_i(iAddr), .i_resp_valid_o(iRespValid),
        .i_resp_data_o(iRespData), .i_access_fault_o(iFault),
        .d_req_valid_i(dReq), .d_req_addr_i(dAddr), .d_resp_valid_o(dRespValid),
        .d_resp_data_o(dRespData), .d_access_fault_o(dFault),
        .m_arvalid_o(arValid), .m_arready_i(arReady), .m_araddr_o(arAddr), .m_arid_o(arId),
        .m_arlen_o(arLen), .m_arsize_o(arSize), .m_arburst_o(arBurst), .m_arprot_o(arProt),
        .m_rvalid_i(rValid), .m_rready_o(rReady), .m_rdata_i(rData), .m_rresp_i(rResp),
        .m_rlast_i(1'b1), .m_rid_i(1'b0)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Pulse one or both TLB requests for one cycle; returns on the negedge after capture.
    task automatic applyStimulus(input logic doI, input logic [63:0] aI,
                                 input logic doD, input logic [63:0] aD);
        iReq = doI; iAddr = aI; dReq = doD; dAddr = aD;
        @(negedge clk);
        iReq = 1'b0; dReq = 1'b0;
    endtask

    task automatic waitArvalid();
        int n = 0;
        while (!arValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!arValid) checkOutput("arvalid_timeout", 0, 1);
    endtask

    task automatic waitRready();
        int n = 0;
        while (!rReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rReady) checkOutput("rready_timeout", 0, 1);
    endtask

    // Present one R beat after 'delay' idle cycles; returns on the negedge after the handshake.
    task automatic serveRead(input logic [63:0] data, input logic [1:0] resp, input int delay);
        waitRready();
        repeat (delay) @(negedge clk);
        rValid = 1'b1; rData = data; rResp = resp;
        @(negedge clk);
        rValid = 1'b0;
    endtask

    // One full transaction with an expected owner and address, checking the response pulse.
    task automatic issueAndServe(input logic expId, input logic [55:0] expAddr,
                                 input logic [63:0] data, input logic [1:0] resp,
                                 input logic expFault, input string tag);
        waitArvalid();
        checkOutput({tag, "_arid"}, 64'(arId), 64'(expId));
        checkOutput({tag, "_araddr"}, 64'(arAddr), 64'(expAddr));
        serveRead(data, resp, 0);
        checkOutput({tag, "_ivalid"}, 64'(iRespValid), 64'(!expId));
        checkOutput({tag, "_dvalid"}, 64'(dRespValid), 64'(expId));
        checkOutput({tag, "_data"}, expId ? dRespData : iRespData, data);
        checkOutput({tag, "_fault"}, 64'(expId ? dFault : iFault), 64'(expFault));
    endtask

    initial begin
        bit seen;

        repeat (3) @(negedge clk);
        checkOutput("rst_arvalid", 64'(arValid), 0);
        checkOutput("rst_rready", 64'(rReady), 0);
        checkOutput("rst_araddr", 64'(arAddr), 0);
        checkOutput("rst_resp", 64'({iRespValid, dRespValid, iFault, dFault}), 0);
        rstn = 1'b1;
        @(negedge clk);

        // Single ITLB read with fixed AR fields and delayed data.
        applyStimulus(1'b1, 64'h8000_1238, 1'b0, '0);
        checkOutput("t1_arvalid", 64'(arValid), 1);
        checkOutput("t1_araddr", 64'(arAddr), 64'h8000_1238);
        checkOutput("t1_arid", 64'(arId), 0);
        checkOutput("t1_arprot", 64'(arProt), 64'(3'b101));
        checkOutput("t1_fixed", 64'({arLen, arSize, arBurst}), 64'({8'd0, 3'd3, 2'b01}));
        serveRead(64'h0000_0000_2000_00CF, 2'b00, 2);
        checkOutput("t1_ivalid", 64'(iRespValid), 1);
        checkOutput("t1_idata", iRespData, 64'h0000_0000_2000_00CF);
        checkOutput("t1_dvalid", 64'(dRespValid), 0);
        @(negedge clk);
        checkOutput("t1_ivalid_pulse", 64'(iRespValid), 0);
        checkOutput("t1_idata_held", iRespData, 64'h0000_0000_2000_00CF);

        // Simultaneous pulses: I wins first, then D wins the next contention.
        applyStimulus(1'b1, 64'h0000_0000_0000_1100, 1'b1, 64'h0000_0000_0000_2200);
        issueAndServe(1'b0, 56'h1100, 64'h1111, 2'b00, 1'b0, "t2a_i");
        issueAndServe(1'b1, 56'h2200, 64'h2222, 2'b00, 1'b0, "t2a_d");
        @(negedge clk);
        applyStimulus(1'b1, 64'h0000_0000_0000_3300, 1'b1, 64'h0000_0000_0000_4400);
        issueAndServe(1'b1, 56'h4400, 64'h4444, 2'b00, 1'b0, "t2b_d");
        issueAndServe(1'b0, 56'h3300, 64'h3333, 2'b00, 1'b0, "t2b_i");
        @(negedge clk);

        // AR held stable under back-pressure; unaligned low bits are cleared.
        arReady = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, 64'h0000_0000_8000_1005);
        seen = 1'b0;
        repeat (5) begin
            if (!arValid || arAddr !== 56'h8000_1000 || arId !== 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("t3_ar_unstable", 64'(seen), 0);
        checkOutput("t3_araddr", 64'(arAddr), 64'h8000_1000);
        arReady = 1'b1;
        @(negedge clk);
        checkOutput("t3_after_hs", 64'({arValid, rReady}), 64'(2'b01));
        serveRead(64'h5555, 2'b00, 0);
        checkOutput("t3_dvalid", 64'(dRespValid), 1);
        @(negedge clk);

        // SLVERR flags a fault on the pulse; the next OKAY read clears it.
        applyStimulus(1'b0, '0, 1'b1, 64'h0000_0000_0000_0040);
        issueAndServe(1'b1, 56'h40, 64'hDEAD, 2'b10, 1'b1, "t4_err");
        @(negedge clk);
        checkOutput("t4_dvalid_pulse", 64'(dRespValid), 0);
        applyStimulus(1'b0, '0, 1'b1, 64'h0000_0000_0000_0048);
        issueAndServe(1'b1, 56'h48, 64'hBEEF, 2'b00, 1'b0, "t4_ok");
        @(negedge clk);

        // Flush while in R with D pending: read completes silently, D never issues.
        applyStimulus(1'b1, 64'h0000_0000_0000_0800, 1'b0, '0);
        waitRready();
        dReq = 1'b1; dAddr = 64'h0000_0000_0000_0900;
        @(negedge clk);
        dReq = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("t5_still_r", 64'(rReady), 1);
        rValid = 1'b1; rData = 64'h7777;
        @(negedge clk);
        rValid = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            if (iRespValid || dRespValid || arValid) seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("t5_no_activity", 64'(seen), 0);
        checkOutput("t5_idle", 64'({arValid, rReady}), 0);

        // Reset in R abandons the read; a late RVALID yields nothing.
        applyStimulus(1'b0, '0, 1'b1, 64'h0000_0000_0000_0A00);
        waitRready();
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("t6_bus", 64'({arValid, rReady, arAddr}), 0);
        checkOutput("t6_idata", iRespData, 0);
        checkOutput("t6_ddata", dRespData, 0);
        checkOutput("t6_flags", 64'({iRespValid, dRespValid, iFault, dFault, arProt}), 0);
        rstn = 1'b1;
        rValid = 1'b1; rData = 64'h9999;
        @(negedge clk);
        rValid = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            if (iRespValid || dRespValid || arValid) seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("t6_late_rvalid", 64'(seen), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
